// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared decode constants and multiply/divide sequencer state for pipeline_hazard_ctrl.
package pipeline_hazard_ctrl_pkg;

  localparam int unsigned OP_W  = 5;
  localparam int unsigned REG_W = 5;

  localparam logic [OP_W-1:0] OP_ALU  = 5'b00000;
  localparam logic [OP_W-1:0] OP_LW   = 5'b01000;
  localparam logic [OP_W-1:0] ALU_MUL = 5'b00110;
  localparam logic [OP_W-1:0] ALU_DIV = 5'b00111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MD_WAIT = 2'd1,
    ST_MD_DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_md_fsm.sv
// Multiply/divide handshake sequencer: state register, wait counter and sticky timeout flag.
module hazard_md_fsm
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MD_TIMEOUT = 40
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      md_start,
  input  logic      md_rdy,
  output md_state_e state,
  output logic      md_timeout
);

  localparam int unsigned CNT_W = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (md_start) begin
          state_d = ST_MD_WAIT;
          cnt_d   = '0;
        end
      end
      ST_MD_WAIT: begin
        // md_rdy wins over the timeout in the last wait cycle
        if (md_rdy) begin
          state_d = ST_MD_DONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = ST_MD_DONE;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_MD_DONE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign state      = state_q;
  assign md_timeout = timeout_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: mul/div handshake, load-use and branch flush.
// Optional stall-cycle counter enabled by HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MD_TIMEOUT = 40
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OP_W-1:0]  opcode_dx,
  input  logic [OP_W-1:0]  aluop_dx,
  input  logic [REG_W-1:0] rd_dx,
  input  logic [REG_W-1:0] rs1_fd,
  input  logic [REG_W-1:0] rs2_fd,
  input  logic             branch_taken_x,
  input  logic             md_rdy,
  output logic             pc_en,
  output logic             fd_en,
  output logic             dx_en,
  output logic             fd_flush,
  output logic             dx_flush,
  output logic             xm_bubble,
  output logic             ctrl_mult,
  output logic             ctrl_div,
  output logic             md_sel,
  output logic             md_timeout,
  output logic [31:0]      stall_count
);

  md_state_e state;
  logic      is_mul, is_div, is_load, load_use, md_start;

  assign is_mul   = (opcode_dx == OP_ALU) && (aluop_dx == ALU_MUL);
  assign is_div   = (opcode_dx == OP_ALU) && (aluop_dx == ALU_DIV);
  assign is_load  = (opcode_dx == OP_LW);
  assign load_use = is_load && (rd_dx != '0) && ((rd_dx == rs1_fd) || (rd_dx == rs2_fd));
  assign md_start = reset && (state == ST_IDLE) && !branch_taken_x && (is_mul || is_div);

  hazard_md_fsm #(.MD_TIMEOUT(MD_TIMEOUT)) u_md_fsm (
    .clk        (clk),
    .reset      (reset),
    .md_start   (md_start),
    .md_rdy     (md_rdy),
    .state      (state),
    .md_timeout (md_timeout)
  );

  // Priority: taken branch > mul/div start > load-use > normal flow; reset forces idle values.
  always_comb begin
    pc_en     = 1'b1;
    fd_en     = 1'b1;
    dx_en     = 1'b1;
    fd_flush  = 1'b0;
    dx_flush  = 1'b0;
    xm_bubble = 1'b0;
    ctrl_mult = 1'b0;
    ctrl_div  = 1'b0;
    md_sel    = 1'b0;
    if (reset) begin
      case (state)
        ST_IDLE: begin
          if (branch_taken_x) begin
            fd_flush = 1'b1;
            dx_flush = 1'b1;
          end else if (is_mul || is_div) begin
            ctrl_mult = is_mul;
            ctrl_div  = is_div;
            pc_en     = 1'b0;
            fd_en     = 1'b0;
            dx_en     = 1'b0;
            xm_bubble = 1'b1;
          end else if (load_use) begin
            pc_en    = 1'b0;
            fd_en    = 1'b0;
            dx_flush = 1'b1;
          end
        end
        ST_MD_WAIT: begin
          pc_en     = 1'b0;
          fd_en     = 1'b0;
          dx_en     = 1'b0;
          xm_bubble = 1'b1;
        end
        ST_MD_DONE: md_sel = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_count_q, stall_count_d;

  always_comb begin
    stall_count_d = stall_count_q;
    if (!pc_en && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;
`else
  assign stall_count = 32'd0;
`endif

endmodule
